// File: rtl/pe_link_mailbox.sv
// Elastic in-order message buffer for one PE-to-PE link: a DEPTH-entry FIFO with registered
// ready/valid. Optional statistics (high_water, push_stall) are enabled by `define MAILBOX_STATS_EN.
module pe_link_mailbox #(
    parameter int MSG_WIDTH  = 48,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MSG_WIDTH-1:0]  in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MSG_WIDTH-1:0]  out_value,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef MAILBOX_STATS_EN
    output logic [ADDR_WIDTH:0]   high_water,
    output logic [15:0]           push_stall,
`endif
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [MSG_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   occ_nxt;
    logic                  push, pop;

    // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (occupancy != FULL_CNT);
    assign out_valid = (occupancy != '0);
    assign out_value = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_nxt = occupancy;
        case ({push, pop})
            2'b10:   occ_nxt = occupancy + 1'b1;
            2'b01:   occ_nxt = occupancy - 1'b1;
            default: occ_nxt = occupancy;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_value;
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            occupancy <= occ_nxt;
        end
    end

`ifdef MAILBOX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            high_water <= '0;
            push_stall <= '0;
        end else begin
            if (occ_nxt > high_water) high_water <= occ_nxt;
            if (in_valid && !in_ready && push_stall != 16'hFFFF) push_stall <= push_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_link_mailbox.sv
// Self-checking bench for pe_link_mailbox: directed scenarios plus randomized traffic against a
// queue-based reference model. Define MAILBOX_STATS_EN to also check the statistics ports.
module tb_pe_link_mailbox;
    localparam int W = 48;
    localparam int DEPTH = 4;

    logic         clk = 0;
    logic         reset;
    logic [W-1:0] in_value;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_value;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   occupancy;
`ifdef MAILBOX_STATS_EN
    logic [2:0]   high_water;
    logic [15:0]  push_stall;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: the buffer contents as a plain queue plus statistics.
    logic [W-1:0] mq[$];
    int           m_hw;
    int           m_stall;

    always #5 clk = ~clk;

    pe_link_mailbox #(.MSG_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
        .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MAILBOX_STATS_EN
        .high_water(high_water), .push_stall(push_stall),
`endif
        .occupancy(occupancy)
    );

    // Advance one clock edge, updating the model from the inputs presented before the edge.
    task automatic tick(output bit acc, output bit popped, output logic [W-1:0] pval);
        bit full, empty;
        full   = (mq.size() == DEPTH);
        empty  = (mq.size() == 0);
        acc    = !reset && in_valid && !full;
        popped = !reset && out_ready && !empty;
        pval   = empty ? '0 : mq[0];
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_hw = 0;
            m_stall = 0;
        end else begin
            if (in_valid && full && m_stall < 65535) m_stall++;
            if (popped) void'(mq.pop_front());
            if (acc) mq.push_back(in_value);
            if (mq.size() > m_hw) m_hw = mq.size();
        end
        #1;
    endtask

    task automatic test_reset();
        bit a, p; logic [W-1:0] v;
        reset = 1; in_valid = 0; out_ready = 0; in_value = '0;
        repeat (10) tick(a, p, v);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_value !== '0) begin fails++; $display("FAIL reset_out_value got %h want 0", out_value); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        reset = 0;
        tick(a, p, v);
    endtask

    task automatic test_single();
        bit a, p; logic [W-1:0] v;
        logic [W-1:0] msg = 48'h4243_4386_F5A1;
        in_value = msg; in_valid = 1; out_ready = 1;
        tick(a, p, v);
        in_valid = 0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (out_value !== msg) begin fails++; $display("FAIL single_value got %h want %h", out_value, msg); end
        tick(a, p, v);
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL single_drain_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_fill();
        bit a, p; logic [W-1:0] v;
        logic [W-1:0] msgs [5];
        int idx = 0, ndel = 0, npop = 0;
        for (int i = 0; i < 5; i++) msgs[i] = {$urandom(), 16'(i)};
        out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            in_value = msgs[idx]; in_valid = 1;
            tick(a, p, v);
            if (a) idx++;
        end
        tests++; if (idx !== 4) begin fails++; $display("FAIL fill_accepted got %0d want 4", idx); end
        tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL fill_occ got %0d want 4", occupancy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        tests++; if (out_value !== msgs[0]) begin fails++; $display("FAIL fill_head got %h want %h", out_value, msgs[0]); end
        out_ready = 1;
        for (int c = 0; c < 20 && ndel < 5; c++) begin
            if (out_valid) begin
                tests++;
                if (out_value !== msgs[ndel]) begin fails++; $display("FAIL fill_order[%0d] got %h want %h", ndel, out_value, msgs[ndel]); end
                ndel++;
            end
            in_value = msgs[idx < 5 ? idx : 4]; in_valid = (idx < 5);
            tick(a, p, v);
            if (p) npop++;
            if (npop == 1 && p) begin
                tests++; if (a) begin fails++; $display("FAIL fill_e_early got accept=1 want 0 on first pop"); end
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_reopen got %b want 1", in_ready); end
            end else if (npop == 2 && p) begin
                tests++; if (!a || idx != 4) begin fails++; $display("FAIL fill_e_accept got acc=%b idx=%0d want acc=1 idx=4", a, idx); end
            end
            if (a) idx++;
        end
        in_valid = 0;
        tests++; if (ndel !== 5) begin fails++; $display("FAIL fill_delivered got %0d want 5", ndel); end
`ifdef MAILBOX_STATS_EN
        tests++; if (high_water !== 3'd4) begin fails++; $display("FAIL stats_high_water got %0d want 4", high_water); end
        tests++; if (push_stall !== 16'd3) begin fails++; $display("FAIL stats_push_stall got %0d want 3", push_stall); end
        reset = 1; tick(a, p, v); reset = 0;
        tests++; if (high_water !== 3'd0) begin fails++; $display("FAIL stats_hw_reset got %0d want 0", high_water); end
        tests++; if (push_stall !== 16'd0) begin fails++; $display("FAIL stats_stall_reset got %0d want 0", push_stall); end
`endif
    endtask

    task automatic test_streaming();
        bit a, p; logic [W-1:0] v;
        logic [W-1:0] nxt_in = 48'h1000, nxt_out = 48'h1000;
        int ndel = 0, bad_occ = 0;
        in_valid = 1; out_ready = 1;
        for (int c = 0; c < 100; c++) begin
            in_value = nxt_in;
            tick(a, p, v);
            if (a) nxt_in++;
            if (p) begin
                tests++;
                if (v !== nxt_out) begin fails++; $display("FAIL stream_model_order got %h want %h", v, nxt_out); end
                nxt_out++; ndel++;
            end
            if (occupancy !== 3'd1) bad_occ++;
            if (out_valid && out_value !== nxt_out) begin
                fails++; $display("FAIL stream_head got %h want %h", out_value, nxt_out);
            end
        end
        in_valid = 0;
        for (int c = 0; c < 4 && out_valid; c++) begin
            tests++; if (out_value !== nxt_out) begin fails++; $display("FAIL stream_tail got %h want %h", out_value, nxt_out); end
            tick(a, p, v); nxt_out++; ndel++;
        end
        tests++; if (bad_occ !== 0) begin fails++; $display("FAIL stream_occ_const got %0d bad cycles want 0", bad_occ); end
        tests++; if (ndel !== 100) begin fails++; $display("FAIL stream_count got %0d want 100", ndel); end
    endtask

    task automatic test_reset_mid();
        bit a, p; logic [W-1:0] v;
        logic [W-1:0] fresh = 48'hABCD_0123_4567;
        int stale = 0;
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_value = 48'hDEAD_0000_0000 + W'(i); tick(a, p, v); end
        tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rmid_pre_occ got %0d want 3", occupancy); end
        reset = 1; in_value = 48'hDEAD_FFFF_FFFF; out_ready = 1;
        tick(a, p, v);
        reset = 0; in_valid = 0;
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL rmid_occ got %0d want 0", occupancy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        tests++; if (out_value !== '0) begin fails++; $display("FAIL rmid_value got %h want 0", out_value); end
        for (int c = 0; c < 5; c++) begin tick(a, p, v); if (out_valid) stale++; end
        in_value = fresh; in_valid = 1;
        tick(a, p, v);
        in_valid = 0;
        tests++; if (stale !== 0) begin fails++; $display("FAIL rmid_stale got %0d want 0", stale); end
        tests++; if (out_valid !== 1'b1 || out_value !== fresh) begin
            fails++; $display("FAIL rmid_fresh got %b/%h want 1/%h", out_valid, out_value, fresh); end
        tick(a, p, v);
    endtask

    task automatic test_random();
        bit a = 1, p; logic [W-1:0] v;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            tests++;
            if (occupancy !== 3'(mq.size()) || in_ready !== (mq.size() != DEPTH) ||
                out_valid !== (mq.size() != 0) || (mq.size() != 0 && out_value !== mq[0])) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_cycle%0d got occ=%0d rdy=%b vld=%b val=%h want occ=%0d head=%h",
                    c, occupancy, in_ready, out_valid, out_value, mq.size(), (mq.size() != 0) ? mq[0] : '0);
            end
`ifdef MAILBOX_STATS_EN
            tests++;
            if (high_water !== 3'(m_hw) || push_stall !== 16'(m_stall)) begin
                fails++; $display("FAIL rand_stats got hw=%0d st=%0d want hw=%0d st=%0d", high_water, push_stall, m_hw, m_stall);
            end
`endif
            if (!in_valid || a) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_value = {$urandom(), 16'($urandom())};
            end
            out_ready = ($urandom_range(0, 99) < (c < 200 ? 40 : 70));
            tick(a, p, v);
        end
    endtask

    initial begin
        m_hw = 0; m_stall = 0;
        reset = 1; in_valid = 0; out_ready = 0; in_value = '0;
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
